// File: rtl/fppu_result_collector.sv
// Collects finished results from both FPU cores into a shared FIFO tagged by source core,
// and drains them one per cycle over a valid/ready stream with a sticky overflow flag.
module fppu_result_collector #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         g0,
   input  logic                     fi0,
   input  logic [WIDTH-1:0]         g1,
   input  logic                     fi1,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_core,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef struct packed {
      logic             core;
      logic [WIDTH-1:0] data;
   } entry_t;

   entry_t        mem_q [DEPTH];

   logic          fi0_q, fi0_d;
   logic          fi1_q, fi1_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          overflow_q, overflow_d;

   logic          ev0, ev1, pop, acc0, acc1;
   logic [LW-1:0] free, n_acc;
   logic          we_a, we_b;
   logic [PW-1:0] wa_a, wa_b;
   entry_t        wd_a, wd_b;

   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      fi0_d      = fi0;
      fi1_d      = fi1;
      ev0        = fi0 & ~fi0_q;
      ev1        = fi1 & ~fi1_q;
      pop        = (level_q != '0) & out_ready;

      // A same-cycle pop frees its slot for this cycle's writes.
      free       = LW'(DEPTH) - level_q + LW'(pop);
      acc0       = ev0 & (free != '0);
      acc1       = ev1 & (acc0 ? (free >= LW'(2)) : (free != '0));
      n_acc      = LW'(acc0) + LW'(acc1);

      we_a       = acc0 | acc1;
      wa_a       = wr_ptr_q;
      wd_a       = acc0 ? '{core: 1'b0, data: g0} : '{core: 1'b1, data: g1};
      we_b       = acc0 & acc1;
      wa_b       = wr_ptr_q + PW'(1);
      wd_b       = '{core: 1'b1, data: g1};

      wr_ptr_d   = wr_ptr_q + PW'(n_acc);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      level_d    = level_q + n_acc - LW'(pop);
      overflow_d = overflow_q | (ev0 & ~acc0) | (ev1 & ~acc1);
   end

   // NOTE: sequential state is updated only with non-blocking assignments so all flops
   // sample their inputs from the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         fi0_q      <= 1'b0;
         fi1_q      <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         fi0_q      <= fi0_d;
         fi1_q      <= fi1_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: storage is deliberately not reset; level gates out_valid, so stale contents are never seen.
   always_ff @(posedge clk) begin
      if (we_a) mem_q[wa_a] <= wd_a;
      if (we_b) mem_q[wa_b] <= wd_b;
   end

   assign out_valid = (level_q != '0);
   assign out_data  = mem_q[rd_ptr_q].data;
   assign out_core  = mem_q[rd_ptr_q].core;
   assign level     = level_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_fppu_result_collector.sv
// Directed bench for fppu_result_collector: capture, ordering, overflow, reset and
// same-cycle pop/push behaviour with hand-computed expectations.
module tb_fppu_result_collector;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] g0, g1;
   logic             fi0, fi1;
   logic             out_valid, out_ready, out_core, overflow;
   logic [WIDTH-1:0] out_data;
   logic [3:0]       level;

   int n_checks = 0;
   int n_errors = 0;

   fppu_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .g0        (g0),
      .fi0       (fi0),
      .g1        (g1),
      .fi1       (fi1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_core  (out_core),
      .level     (level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic pulse0(input logic [WIDTH-1:0] v);
      g0  = v;
      fi0 = 1'b1;
      tick();
      fi0 = 1'b0;
      tick();
   endtask

   // Check the head against the expectation, then pop it.
   task automatic pop_check(input string tag, input logic core, input logic [WIDTH-1:0] data);
      check({tag, "_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_core"},  64'(out_core),  64'(core));
      check({tag, "_data"},  64'(out_data),  64'(data));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0; g0 = '0; g1 = '0; fi0 = 1'b0; fi1 = 1'b0; out_ready = 1'b0;

      // 1: reset state, then single pulse with consumer ready
      do_reset();
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_level", 64'(level),     64'(0));
      check("rst_ovf",   64'(overflow),  64'(0));
      out_ready = 1'b1;
      g0 = 32'h3F80_0000; fi0 = 1'b1;
      tick();
      fi0 = 1'b0;
      check("t1_valid", 64'(out_valid), 64'(1));
      check("t1_data",  64'(out_data),  64'h3F80_0000);
      check("t1_core",  64'(out_core),  64'(0));
      tick();
      check("t1_level", 64'(level),     64'(0));
      check("t1_empty", 64'(out_valid), 64'(0));
      out_ready = 1'b0;

      // 2: both cores fire in one cycle, core0 first
      g0 = 32'h4000_0000; g1 = 32'h4040_0000; fi0 = 1'b1; fi1 = 1'b1;
      tick();
      fi0 = 1'b0; fi1 = 1'b0;
      check("t2_level", 64'(level), 64'(2));
      pop_check("t2_h0", 1'b0, 32'h4000_0000);
      check("t2_level1", 64'(level), 64'(1));
      pop_check("t2_h1", 1'b1, 32'h4040_0000);
      check("t2_level0", 64'(level), 64'(0));

      // 3: level held high captures once
      g1 = 32'h4080_0000; fi1 = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      fi1 = 1'b0;
      tick();
      check("t3_level", 64'(level), 64'(1));
      pop_check("t3_h", 1'b1, 32'h4080_0000);

      // 4: nine pulses into an eight-deep FIFO
      for (int i = 0; i < 9; i++) pulse0(32'h100 + 32'(i));
      check("t4_level", 64'(level),    64'(8));
      check("t4_ovf",   64'(overflow), 64'(1));
      for (int i = 0; i < 8; i++) pop_check($sformatf("t4_p%0d", i), 1'b0, 32'h100 + 32'(i));
      check("t4_empty",    64'(level),    64'(0));
      check("t4_ovf_stky", 64'(overflow), 64'(1));

      // 5: level 7, both fire while popping -> both accepted
      do_reset();
      check("t5_ovf_clr", 64'(overflow), 64'(0));
      for (int i = 0; i < 7; i++) pulse0(32'h200 + 32'(i));
      check("t5_level7", 64'(level), 64'(7));
      g0 = 32'hAAAA_0000; g1 = 32'hBBBB_0000; fi0 = 1'b1; fi1 = 1'b1; out_ready = 1'b1;
      tick();
      fi0 = 1'b0; fi1 = 1'b0; out_ready = 1'b0;
      check("t5_level8", 64'(level),    64'(8));
      check("t5_ovf",    64'(overflow), 64'(0));
      for (int i = 1; i < 7; i++) pop_check($sformatf("t5_p%0d", i), 1'b0, 32'h200 + 32'(i));
      pop_check("t5_pa", 1'b0, 32'hAAAA_0000);
      pop_check("t5_pb", 1'b1, 32'hBBBB_0000);
      check("t5_empty", 64'(out_valid), 64'(0));

      // 6: reset mid-stream discards entries; fi high through reset captures once
      for (int i = 0; i < 5; i++) pulse0(32'h300 + 32'(i));
      check("t6_level5", 64'(level), 64'(5));
      g0 = 32'hCAFE_F00D; fi0 = 1'b1;
      do_reset();
      check("t6_valid", 64'(out_valid), 64'(0));
      check("t6_level", 64'(level),     64'(0));
      check("t6_ovf",   64'(overflow),  64'(0));
      tick();
      tick();
      fi0 = 1'b0;
      check("t6_cap_level", 64'(level), 64'(1));
      pop_check("t6_h", 1'b0, 32'hCAFE_F00D);
      pulse0(32'h1234_5678);
      check("t6_level1", 64'(level), 64'(1));
      pop_check("t6_h2", 1'b0, 32'h1234_5678);
      check("t6_end", 64'(level), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
